// File: rtl/kdf_stream_if.sv
// kdf_stream_if: 256-bit key word stream, valid/ready handshake.
// master drives the key words, slave returns ready.
interface kdf_stream_if;
    logic [255:0] kout_data;
    logic         kout_valid;
    logic         kout_ready;
    logic         kout_last;
    logic [8:0]   kout_nbits;

    modport master (
        output kout_data,
        output kout_valid,
        output kout_last,
        output kout_nbits,
        input  kout_ready
    );

    modport slave (
        input  kout_data,
        input  kout_valid,
        input  kout_last,
        input  kout_nbits,
        output kout_ready
    );
endinterface

// File: rtl/kdf_stream.sv
// kdf_stream: SM2 KDF engine, K = H(Z||1) || H(Z||2) || ... truncated to klen.
// Optional KDF_ZERO_CHECK_EN adds kout_zero (all delivered key bits zero).
module kdf_stream #(
    parameter int ZW      = 512,
    parameter int MAXKLEN = 4096,
    parameter int CTW     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ZW-1:0]     zin,
    input  logic [31:0]       klen,
    input  logic              start,
    output logic              busy,
    output logic              err,
    output logic              h_start,
    output logic [ZW+CTW-1:0] h_msg,
    input  logic              h_done,
    input  logic [255:0]      h_digest,
`ifdef KDF_ZERO_CHECK_EN
    output logic              kout_zero,
`endif
    kdf_stream_if.master      kout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t         state_q, state_d;
    logic [ZW-1:0]  z_q, z_d;
    logic [7:0]     r_q, r_d;
    logic [CTW-1:0] nblk_q, nblk_d;
    logic [CTW-1:0] ct_q, ct_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic [255:0]   kd_q, kd_d;
    logic           kv_q, kv_d;
    logic           kl_q, kl_d;
    logic [8:0]     kn_q, kn_d;
`ifdef KDF_ZERO_CHECK_EN
    logic           nz_q, nz_d;
    logic           zero_q, zero_d;
`endif

    logic           klen_ok;
    logic [31:0]    nblk_w;
    logic           last_w;
    logic           part_w;
    logic [255:0]   mask_w;
    logic [255:0]   word_w;
    logic [8:0]     nbits_w;

    assign klen_ok = (klen != 32'd0) && (klen <= 32'(MAXKLEN));
    assign nblk_w  = (klen + 32'd255) >> 8;
    assign last_w  = (ct_q == nblk_q);
    assign part_w  = last_w && (r_q != 8'd0);
    assign mask_w  = part_w ? ~({256{1'b1}} >> r_q) : {256{1'b1}};
    assign word_w  = h_digest & mask_w;
    assign nbits_w = part_w ? {1'b0, r_q} : 9'd256;

    // Next-state, counter and output-word logic for the KDF sequencer
    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        r_d     = r_q;
        nblk_d  = nblk_q;
        ct_d    = ct_q;
        busy_d  = busy_q;
        err_d   = 1'b0;
        kd_d    = kd_q;
        kv_d    = kv_q;
        kl_d    = kl_q;
        kn_d    = kn_q;
`ifdef KDF_ZERO_CHECK_EN
        nz_d    = nz_q;
        zero_d  = zero_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (klen_ok) begin
                        z_d     = zin;
                        r_d     = klen[7:0];
                        nblk_d  = nblk_w[CTW-1:0];
                        ct_d    = CTW'(1);
                        busy_d  = 1'b1;
                        state_d = S_REQ;
`ifdef KDF_ZERO_CHECK_EN
                        nz_d    = 1'b0;
                        zero_d  = 1'b0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (h_done) begin
                    kd_d    = word_w;
                    kl_d    = last_w;
                    kn_d    = nbits_w;
                    kv_d    = 1'b1;
                    state_d = S_OUT;
`ifdef KDF_ZERO_CHECK_EN
                    nz_d    = nz_q | (|word_w);
                    zero_d  = last_w & ~(nz_q | (|word_w));
`endif
                end
            end
            S_OUT: begin
                if (kv_q && kout.kout_ready) begin
                    kv_d = 1'b0;
                    if (kl_q) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        ct_d    = ct_q + CTW'(1);
                        state_d = S_REQ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            z_q     <= '0;
            r_q     <= '0;
            nblk_q  <= '0;
            ct_q    <= CTW'(1);
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            kd_q    <= '0;
            kv_q    <= 1'b0;
            kl_q    <= 1'b0;
            kn_q    <= '0;
`ifdef KDF_ZERO_CHECK_EN
            nz_q    <= 1'b0;
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            r_q     <= r_d;
            nblk_q  <= nblk_d;
            ct_q    <= ct_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            kd_q    <= kd_d;
            kv_q    <= kv_d;
            kl_q    <= kl_d;
            kn_q    <= kn_d;
`ifdef KDF_ZERO_CHECK_EN
            nz_q    <= nz_d;
            zero_q  <= zero_d;
`endif
        end
    end

    assign busy            = busy_q;
    assign err             = err_q;
    assign h_start         = (state_q == S_REQ);
    // idle message is all-zero; ct itself rests at 1
    assign h_msg           = busy_q ? {z_q, ct_q} : '0;
    assign kout.kout_data  = kd_q;
    assign kout.kout_valid = kv_q;
    assign kout.kout_last  = kl_q;
    assign kout.kout_nbits = kn_q;
`ifdef KDF_ZERO_CHECK_EN
    assign kout_zero       = zero_q;
`endif

endmodule

// File: doc/kdf_stream.md
Name: kdf_stream

Overview:
Parameterised SM2 key-derivation engine that computes K = Hash(Z||ct1) || Hash(Z||ct2) || ... and truncates the result to klen bits.
- Drives an external SM3 core through a start/done interface; the SM3 core owns message padding.
- Streams the key out as 256-bit words on a valid/ready port instead of one fixed-width vector.
- Sits between the SM2 shared-secret datapath (supplies Z) and the key consumers (encryption XOR mask, key exchange).

Parameters:
ZW, 512, width of shared-secret input Z in bits (multiple of 8).
MAXKLEN, 4096, largest accepted klen in bits.
CTW, 32, counter width appended to Z (fixed at 32 per SM2; kept as a parameter for h_msg sizing only).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
zin  in  ZW  shared secret Z, sampled on start
klen  in  32  requested key length in bits, sampled on start
start  in  1  single-cycle request pulse
busy  out  1  high from accepted start until the last word handshakes
err  out  1  one-cycle pulse: klen rejected
h_start  out  1  one-cycle pulse to SM3 core
h_msg  out  ZW+CTW  {Z, ct} message, held stable while busy
h_done  in  1  one-cycle pulse: h_digest valid
h_digest  in  256  SM3 result
kout_data  out  256  key word, MSB first; unused tail bits zero
kout_valid  out  1  word valid
kout_ready  in  1  consumer accepts word
kout_last  out  1  marks final word, qualified by kout_valid
kout_nbits  out  9  valid MSBs in current word (1..256)

Behaviour:
- Reset: busy=0, err=0, h_start=0, h_msg=0, kout_data=0, kout_valid=0, kout_last=0, kout_nbits=0, ct=1, FSM=IDLE.
- FSM states: IDLE, REQ, WAIT, OUT.
- IDLE:
  - start with 1<=klen<=MAXKLEN: latch Z and klen; nblk=ceil(klen/256); ct=1; busy=1; go to REQ.
  - start with klen==0 or klen>MAXKLEN: err=1 for exactly one cycle; stay in IDLE; no h_start.
  - start while not in IDLE: ignored.
- REQ: h_start=1 for one cycle with h_msg={Z, ct[31:0]} (ct big-endian); go to WAIT. h_start is asserted the cycle after start is accepted.
- WAIT: on h_done, capture h_digest into kout_data, assert kout_valid the following cycle, go to OUT. h_done is ignored in any other state.
- OUT:
  - Hold kout_data, kout_last and kout_nbits stable while kout_valid=1 and kout_ready=0.
  - On a handshake with last=0: kout_valid drops, ct increments, go to REQ.
  - On a handshake with last=1: kout_valid=0, busy=0, go to IDLE.
- Last word:
  - kout_last=1 when ct==nblk.
  - r = klen mod 256; kout_nbits = r, or 256 when r==0.
  - Bits [255-r:0] are forced to zero when r!=0.
  - All earlier words: kout_nbits=256, kout_last=0.
- ct never wraps: MAXKLEN bounds nblk far below 2^32.
- Reset mid-operation returns to IDLE with all reset values. A late h_done arriving after reset is ignored.
- The block has no internal hashing; the SM3 latency is arbitrary and the FSM simply waits for h_done.

Optional Feature:
KDF_ZERO_CHECK_EN:
- When defined: adds output port kout_zero (1 bit), an accumulating OR of all delivered valid key bits.
  - kout_zero=1 is asserted together with the last word when every output bit is zero (SM2 requires the caller to retry).
  - Held until the next accepted start or reset; reset value 0.
- When undefined: the port and accumulator are absent; behaviour is otherwise identical.

Test Plan:
- Reference Z (512-bit test vector), klen=1000, ready tied high, SM3 model -> four h_start pulses with ct=1,2,3,4; four words; last word kout_nbits=232, bits[23:0]=0, kout_last=1; busy drops after the 4th handshake.
- klen=256 -> exactly one h_start (ct=1), one word, kout_nbits=256, kout_last=1, word equals the SM3 model digest.
- klen=0, then klen=MAXKLEN+1 -> err pulse of one cycle each; h_start never asserted; busy stays 0.
- klen=512, kout_ready held low 5 cycles on word 1 -> kout_data/kout_last stable for all 5 cycles; no second h_start until the handshake.
- rst asserted while in WAIT with klen=1000, then h_done pulsed -> all outputs at reset values; no kout_valid; a following start with klen=256 completes normally.
- KDF_ZERO_CHECK_EN, SM3 model returns all-zero digest, klen=300 -> kout_zero=1 with the last word; a nonzero digest gives kout_zero=0.
